attack_link_rx: RTL and testbench



---
 rtl/link_pkg.sv | 15 +
 rtl/link_bit_timer.sv | 35 +++
 rtl/attack_link_rx.sv | 176 +++++++++++++++++
 tb/tb_attack_link_rx.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/link_pkg.sv
// Types and default constants shared by the inter-board link receiver and transmitter.
package link_pkg;

    localparam int LINK_DATA_W       = 16;
    localparam int LINK_CLKS_PER_BIT = 100;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

endpackage

// File: rtl/link_bit_timer.sv
// Bit-period down-counter for the link: load with a full or half period, ticks for one
// cycle when the count reaches 1 and then reloads a full period by itself.
module link_bit_timer #(
    parameter int CLKS_PER_BIT = 100
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic half,
    output logic tick
);

    // One extra value of headroom so a power-of-two period still fits the counter.
    localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(CLKS_PER_BIT / 2);
    localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= half ? HALF_CNT : FULL_CNT;
        end else if (cnt == ONE_CNT) begin
            cnt <= FULL_CNT;
        end else if (cnt != '0) begin
            cnt <= cnt - ONE_CNT;
        end
    end

    assign tick = (cnt == ONE_CNT);

endmodule

// File: rtl/attack_link_rx.sv
// Attack-word frame receiver: start bit, DATA_W bits LSB first, optional even parity
// (enabled by defining ATTACK_RX_PARITY_EN), one stop bit; valid/ack delivery.
module attack_link_rx
    import link_pkg::*;
#(
    parameter int DATA_W       = LINK_DATA_W,
    parameter int CLKS_PER_BIT = LINK_CLKS_PER_BIT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              bs_in,
    input  logic              sig_in,
    output logic [DATA_W-1:0] data,
    output logic              data_valid,
    input  logic              data_ack,
    output logic              frame_err,
    output logic              overrun
);

    localparam int BCNT_W = $clog2(DATA_W + 1);
    localparam logic [BCNT_W-1:0] LAST_BIT = BCNT_W'(DATA_W - 1);
    localparam logic [BCNT_W-1:0] ONE_BIT  = BCNT_W'(1);

    logic bs_meta, bs, bs_prev;
    logic sig_meta, sig;

    rx_state_t state, state_nxt;

    logic              tick;
    logic              timer_load;
    logic              sample_bit;
    logic              frame_done;
    logic              frame_bad;
    logic              abort;
    logic              par_err;
    logic [BCNT_W-1:0] bit_cnt;
    logic [DATA_W-1:0] shreg;
`ifdef ATTACK_RX_PARITY_EN
    logic              sample_par;
`endif

    // Line idles high, so the bs synchronizer resets high to avoid a fake start edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bs_meta  <= 1'b1;
            bs       <= 1'b1;
            bs_prev  <= 1'b1;
            sig_meta <= 1'b0;
            sig      <= 1'b0;
        end else begin
            bs_meta  <= bs_in;
            bs       <= bs_meta;
            bs_prev  <= bs;
            sig_meta <= sig_in;
            sig      <= sig_meta;
        end
    end

    link_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk  (clk),
        .rst_n(rst_n),
        .load (timer_load),
        .half (state == IDLE),
        .tick (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        timer_load = 1'b0;
        sample_bit = 1'b0;
        frame_done = 1'b0;
        frame_bad  = 1'b0;
        abort      = 1'b0;
`ifdef ATTACK_RX_PARITY_EN
        sample_par = 1'b0;
`endif
        if (state != IDLE && !sig) begin
            state_nxt = IDLE;
            abort     = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (sig && bs_prev && !bs) begin
                        state_nxt  = START;
                        timer_load = 1'b1;
                    end
                end
                START: begin
                    if (tick) state_nxt = bs ? IDLE : DATA;
                end
                DATA: begin
                    if (tick) begin
                        sample_bit = 1'b1;
`ifdef ATTACK_RX_PARITY_EN
                        if (bit_cnt == LAST_BIT) state_nxt = PARITY;
`else
                        if (bit_cnt == LAST_BIT) state_nxt = STOP;
`endif
                    end
                end
`ifdef ATTACK_RX_PARITY_EN
                PARITY: begin
                    if (tick) begin
                        sample_par = 1'b1;
                        state_nxt  = STOP;
                    end
                end
`endif
                STOP: begin
                    if (tick) begin
                        state_nxt = IDLE;
                        if (bs && !par_err) frame_done = 1'b1;
                        else                frame_bad  = 1'b1;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Start-edge load doubles as the per-frame clear of the bit counter and shifter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt <= '0;
            shreg   <= '0;
        end else if (timer_load || abort) begin
            bit_cnt <= '0;
            shreg   <= '0;
        end else if (sample_bit) begin
            bit_cnt <= bit_cnt + ONE_BIT;
            shreg   <= {bs, shreg[DATA_W-1:1]};
        end
    end

`ifdef ATTACK_RX_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          par_err <= 1'b0;
        else if (timer_load) par_err <= 1'b0;
        else if (sample_par) par_err <= (bs != ^shreg);
    end
`else
    assign par_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data       <= '0;
            data_valid <= 1'b0;
            overrun    <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            frame_err <= abort | frame_bad;
            if (frame_done) begin
                // A same-cycle ack frees the slot, so the new word wins.
                if (!data_valid || data_ack) begin
                    data       <= shreg;
                    data_valid <= 1'b1;
                    overrun    <= 1'b0;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (data_ack && data_valid) begin
                data_valid <= 1'b0;
                overrun    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_attack_link_rx.sv
// Directed bench for attack_link_rx; the parity-error step runs when ATTACK_RX_PARITY_EN is defined.
module tb_attack_link_rx;

    localparam int DATA_W = 16;
    localparam int CPB    = 100;
`ifdef ATTACK_RX_PARITY_EN
    localparam int LAT = 1853;
`else
    localparam int LAT = 1753;
`endif

    logic              clk      = 1'b0;
    logic              rst_n    = 1'b0;
    logic              bs_in    = 1'b1;
    logic              sig_in   = 1'b0;
    logic              data_ack = 1'b0;
    logic [DATA_W-1:0] data;
    logic              data_valid;
    logic              frame_err;
    logic              overrun;

    int   checks    = 0;
    int   errors    = 0;
    int   cyc       = 0;
    int   err_cnt   = 0;
    int   start_cyc = 0;
    int   rise_cyc  = 0;
    logic dv_q      = 1'b0;
`ifdef ATTACK_RX_PARITY_EN
    bit   par_flip  = 1'b0;
`endif

    attack_link_rx #(
        .DATA_W      (DATA_W),
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bs_in     (bs_in),
        .sig_in    (sig_in),
        .data      (data),
        .data_valid(data_valid),
        .data_ack  (data_ack),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (frame_err) err_cnt <= err_cnt + 1;
        if (data_valid && !dv_q) rise_cyc <= cyc;
        dv_q <= data_valid;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic ack_pulse();
        data_ack = 1'b1;
        @(negedge clk);
        data_ack = 1'b0;
        #1;
    endtask

    task automatic send_head(input logic [DATA_W-1:0] w, input int nbits, input bit ack_done);
        bs_in     = 1'b0;
        start_cyc = cyc;
        if (ack_done) begin
            fork
                begin
                    repeat (LAT - 1) @(negedge clk);
                    data_ack = 1'b1;
                    @(negedge clk);
                    data_ack = 1'b0;
                end
            join_none
        end
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            bs_in = w[i];
            repeat (CPB) @(negedge clk);
        end
    endtask

    task automatic send_frame(input logic [DATA_W-1:0] w, input bit ack_done);
        send_head(w, DATA_W, ack_done);
`ifdef ATTACK_RX_PARITY_EN
        bs_in = (^w) ^ par_flip;
        repeat (CPB) @(negedge clk);
`endif
        bs_in = 1'b1;
        repeat (CPB) @(negedge clk);
        #1;
    endtask

    initial begin
        int e0;

        wait_n(3);
        check("rst_data", data, 0);
        check("rst_valid", data_valid, 0);
        check("rst_ferr", frame_err, 0);
        check("rst_overrun", overrun, 0);
        rst_n  = 1'b1;
        sig_in = 1'b1;
        wait_n(5);

        e0 = err_cnt;
        send_frame(16'hA5C3, 1'b0);
        check("good_latency", rise_cyc - start_cyc, LAT);
        check("good_data", data, 16'hA5C3);
        check("good_valid", data_valid, 1);
        check("good_ferr", err_cnt - e0, 0);
        ack_pulse();
        check("ack_valid", data_valid, 0);
        check("ack_data_kept", data, 16'hA5C3);

        send_frame(16'h1111, 1'b0);
        send_frame(16'h2222, 1'b0);
        check("ovr_data", data, 16'h1111);
        check("ovr_flag", overrun, 1);
        check("ovr_valid", data_valid, 1);
        ack_pulse();
        check("ovr_ack_valid", data_valid, 0);
        check("ovr_ack_flag", overrun, 0);

        send_frame(16'h1111, 1'b0);
        send_frame(16'h3333, 1'b1);
        check("coin_data", data, 16'h3333);
        check("coin_valid", data_valid, 1);
        check("coin_overrun", overrun, 0);
        ack_pulse();

        e0    = err_cnt;
        bs_in = 1'b0;
        wait_n(20);
        bs_in = 1'b1;
        wait_n(200);
        check("glitch_valid", data_valid, 0);
        check("glitch_data", data, 16'h3333);
        check("glitch_ferr", err_cnt - e0, 0);

`ifdef ATTACK_RX_PARITY_EN
        e0       = err_cnt;
        par_flip = 1'b1;
        send_frame(16'h0001, 1'b0);
        par_flip = 1'b0;
        wait_n(2);
        check("par_ferr", err_cnt - e0, 1);
        check("par_valid", data_valid, 0);
        check("par_data", data, 16'h3333);
`endif

        e0 = err_cnt;
        send_head(16'h5A5A, 8, 1'b0);
        bs_in  = 1'b1;
        sig_in = 1'b0;
        wait_n(10);
        check("abort_ferr", err_cnt - e0, 1);
        check("abort_valid", data_valid, 0);
        check("abort_data", data, 16'h3333);
        sig_in = 1'b1;
        wait_n(10);

        send_frame(16'h1111, 1'b0);
        send_frame(16'h2222, 1'b0);
        send_head(16'h5555, 4, 1'b0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_data", data, 0);
        check("mid_rst_valid", data_valid, 0);
        check("mid_rst_overrun", overrun, 0);
        check("mid_rst_ferr", frame_err, 0);
        bs_in = 1'b1;
        wait_n(3);
        rst_n = 1'b1;
        wait_n(5);

        e0 = err_cnt;
        send_frame(16'hBEEF, 1'b0);
        check("beef_latency", rise_cyc - start_cyc, LAT);
        check("beef_data", data, 16'hBEEF);
        check("beef_valid", data_valid, 1);
        check("beef_ferr", err_cnt - e0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
